// File: rtl/cgra_rd_port_arbiter_pkg.sv
// Shared constants and helpers for the accelerator read-port arbiter.
// Provides clog2, the requester-ID width rule and the fixed requester indices.
package cgra_rd_port_arbiter_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // An ID field is never narrower than one bit.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // The configuration controller is requester 0.
  // The fetch units occupy indices 1..N_REQ-1.
  localparam int REQ_CONF = 0;

endpackage

// File: rtl/cgra_tag_fifo.sv
// Synchronous tag FIFO with show-ahead head and registered full/empty/count.
// Ports: clk, rst (sync, active high), i_push/i_data, i_pop, o_head,
//        o_full, o_empty, o_count (occupancy 0..DEPTH).
module cgra_tag_fifo
  import cgra_rd_port_arbiter_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [W-1:0]          i_data,
  input  logic                  i_pop,
  output logic [W-1:0]          o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int AW = id_width(DEPTH);
  localparam int CW = clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_cnt;

endmodule

// File: rtl/cgra_rd_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory read channel among N_REQ
// requesters; a tag FIFO of granted IDs steers each response to its owner.
// Ports: clk, rst (sync, active high); memory side available_read,
//        request_read, read_data_valid, read_data; client side req_rd,
//        gnt_rd, rd_data_valid, rd_data; status outstanding, idle,
//        err_orphan (sticky until rst).
module cgra_rd_port_arbiter
  import cgra_rd_port_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ID_W       = id_width(N_REQ),
  parameter int MAX_OUTST  = 4,
  parameter int DATA_WIDTH = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      available_read,
  output logic                      request_read,
  input  logic                      read_data_valid,
  input  logic [DATA_WIDTH-1:0]     read_data,
  input  logic [N_REQ-1:0]          req_rd,
  output logic [N_REQ-1:0]          gnt_rd,
  output logic [N_REQ-1:0]          rd_data_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [clog2(MAX_OUTST):0] outstanding,
  output logic                      idle,
  output logic                      err_orphan
);

  logic [ID_W-1:0]            r_ptr;
  logic                       r_err;

  logic                       w_full;
  logic                       w_empty;
  logic [ID_W-1:0]            w_head;
  logic [clog2(MAX_OUTST):0]  w_count;

  logic                       w_can_issue;
  logic                       w_found;
  logic [ID_W-1:0]            w_win;
  logic [ID_W-1:0]            w_ptr_nxt;
  logic                       w_push;
  logic                       w_pop;
  int                         w_idx;

  // Full is the registered flag, so a pop cannot free a slot for a
  // push in the same cycle; that costs one bubble when full.
  assign w_can_issue = available_read & ~w_full & ~rst;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req_rd[w_idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(w_idx);
      end
    end
  end

  always_comb begin
    gnt_rd = '0;
    if (w_can_issue && w_found) gnt_rd[w_win] = 1'b1;
  end

  assign w_push       = |gnt_rd;
  assign request_read = w_push;

  always_comb begin
    w_ptr_nxt = w_win + ID_W'(1);
    if (w_win == ID_W'(N_REQ - 1)) w_ptr_nxt = '0;
  end

  assign w_pop = read_data_valid & ~w_empty & ~rst;

  always_comb begin
    rd_data_valid = '0;
    if (w_pop) rd_data_valid[w_head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= ID_W'(REQ_CONF);
      r_err <= 1'b0;
    end else begin
      if (w_push) r_ptr <= w_ptr_nxt;
      if (read_data_valid && w_empty) r_err <= 1'b1;
    end
  end

  cgra_tag_fifo #(
    .W     (ID_W),
    .DEPTH (MAX_OUTST)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rd_data     = read_data;
  assign outstanding = w_count;
  assign idle        = (w_count == '0) & ~|req_rd;
  assign err_orphan  = r_err;

endmodule

// File: tb/tb_cgra_rd_port_arbiter.sv
// Directed self-checking bench for cgra_rd_port_arbiter (N_REQ=2, depth 4).
// Inputs change 1 time unit after posedge; outputs are checked 3 units later.
module tb_cgra_rd_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         available_read;
  logic         request_read;
  logic         read_data_valid;
  logic [511:0] read_data;
  logic [1:0]   req_rd;
  logic [1:0]   gnt_rd;
  logic [1:0]   rd_data_valid;
  logic [511:0] rd_data;
  logic [2:0]   outstanding;
  logic         idle;
  logic         err_orphan;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  cgra_rd_port_arbiter #(
    .N_REQ      (2),
    .MAX_OUTST  (4),
    .DATA_WIDTH (512)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .available_read  (available_read),
    .request_read    (request_read),
    .read_data_valid (read_data_valid),
    .read_data       (read_data),
    .req_rd          (req_rd),
    .gnt_rd          (gnt_rd),
    .rd_data_valid   (rd_data_valid),
    .rd_data         (rd_data),
    .outstanding     (outstanding),
    .idle            (idle),
    .err_orphan      (err_orphan)
  );

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  logic [1:0] exp_g [4];
  logic [1:0] exp_v [3];

  initial begin
    rst = 1'b1;
    available_read = 1'b1;
    read_data_valid = 1'b0;
    read_data = '0;
    req_rd = 2'b11;
    #1;
    settle();
    chk("rst_gnt", 512'(gnt_rd), 512'(2'b00));
    chk("rst_req", 512'(request_read), 512'(1'b0));
    cyc();
    cyc();
    rst = 1'b0;
    req_rd = 2'b00;
    settle();
    chk("rst_out", 512'(outstanding), 512'(3'd0));
    chk("rst_err", 512'(err_orphan), 512'(1'b0));
    chk("rst_idle", 512'(idle), 512'(1'b1));

    // Test 1: both requesting, alternate until full.
    req_rd = 2'b11;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10;
    exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t1_gnt", 512'(gnt_rd), 512'(exp_g[i]));
      chk("t1_out", 512'(outstanding), 512'(i));
      cyc();
    end
    settle();
    chk("t1_full_gnt", 512'(gnt_rd), 512'(2'b00));
    chk("t1_full_req", 512'(request_read), 512'(1'b0));
    chk("t1_out4", 512'(outstanding), 512'(3'd4));
    chk("t1_idle", 512'(idle), 512'(1'b0));

    // Test 2: drain in order.
    cyc();
    req_rd = 2'b00;
    read_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_data = {16{32'hA5A50000 + 32'(i)}};
      settle();
      chk("t2_rdv", 512'(rd_data_valid), 512'(exp_g[i]));
      chk("t2_data", rd_data, {16{32'hA5A50000 + 32'(i)}});
      chk("t2_out", 512'(outstanding), 512'(4 - i));
      cyc();
    end
    read_data_valid = 1'b0;
    settle();
    chk("t2_out0", 512'(outstanding), 512'(3'd0));
    chk("t2_idle", 512'(idle), 512'(1'b1));
    chk("t2_err", 512'(err_orphan), 512'(1'b0));

    // Test 3: only requester 1, channel availability toggling.
    cyc();
    req_rd = 2'b10;
    for (int i = 0; i < 4; i++) begin
      available_read = (i % 2 == 0);
      settle();
      chk("t3_gnt", 512'(gnt_rd), (i % 2 == 0) ? 512'(2'b10) : 512'(2'b00));
      cyc();
    end
    available_read = 1'b1;
    req_rd = 2'b11;
    settle();
    chk("t3_ptr0", 512'(gnt_rd), 512'(2'b01));
    chk("t3_out", 512'(outstanding), 512'(3'd2));
    cyc();
    req_rd = 2'b00;
    read_data_valid = 1'b1;
    exp_v[0] = 2'b10; exp_v[1] = 2'b10; exp_v[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_rdv", 512'(rd_data_valid), 512'(exp_v[i]));
      cyc();
    end
    read_data_valid = 1'b0;
    settle();
    chk("t3_out0", 512'(outstanding), 512'(3'd0));

    // Test 4: pop while full blocks the same-cycle push.
    req_rd = 2'b01;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_fill", 512'(gnt_rd), 512'(2'b01));
      cyc();
    end
    read_data_valid = 1'b1;
    settle();
    chk("t4_bub_gnt", 512'(gnt_rd), 512'(2'b00));
    chk("t4_bub_rdv", 512'(rd_data_valid), 512'(2'b01));
    chk("t4_out4", 512'(outstanding), 512'(3'd4));
    cyc();
    read_data_valid = 1'b0;
    settle();
    chk("t4_out3", 512'(outstanding), 512'(3'd3));
    chk("t4_gnt", 512'(gnt_rd), 512'(2'b01));
    cyc();
    req_rd = 2'b00;
    settle();
    chk("t4_out4b", 512'(outstanding), 512'(3'd4));
    read_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    read_data_valid = 1'b0;
    settle();
    chk("t4_drain", 512'(outstanding), 512'(3'd0));

    // Test 5: orphan response.
    read_data_valid = 1'b1;
    settle();
    chk("t5_rdv", 512'(rd_data_valid), 512'(2'b00));
    chk("t5_err_pre", 512'(err_orphan), 512'(1'b0));
    cyc();
    read_data_valid = 1'b0;
    settle();
    chk("t5_err", 512'(err_orphan), 512'(1'b1));
    cyc();
    cyc();
    settle();
    chk("t5_sticky", 512'(err_orphan), 512'(1'b1));

    // Test 6: reset with requests in flight, pointer left at 1.
    req_rd = 2'b01;
    for (int i = 0; i < 3; i++) cyc();
    req_rd = 2'b00;
    settle();
    chk("t6_out3", 512'(outstanding), 512'(3'd3));
    cyc();
    rst = 1'b1;
    req_rd = 2'b11;
    read_data_valid = 1'b1;
    settle();
    chk("t6_rst_gnt", 512'(gnt_rd), 512'(2'b00));
    chk("t6_rst_rdv", 512'(rd_data_valid), 512'(2'b00));
    cyc();
    rst = 1'b0;
    read_data_valid = 1'b0;
    settle();
    chk("t6_out0", 512'(outstanding), 512'(3'd0));
    chk("t6_err0", 512'(err_orphan), 512'(1'b0));
    chk("t6_gnt", 512'(gnt_rd), 512'(2'b01));
    cyc();
    settle();
    chk("t6_gnt2", 512'(gnt_rd), 512'(2'b10));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
